// File: rtl/teclado_pkg.sv
// Shared types and constants for the Bluetooth text-command receiver.
// Command codes, ASCII constants, parser/UART state encodings and the keyword table.
package teclado_pkg;

  typedef enum logic [3:0] {
    CMD_NONE  = 4'd0,
    CMD_UP    = 4'd1,
    CMD_DOWN  = 4'd2,
    CMD_LEFT  = 4'd3,
    CMD_RIGHT = 4'd4,
    CMD_PAINT = 4'd5,
    CMD_ERASE = 4'd6,
    CMD_CLEAR = 4'd7,
    CMD_COLOR = 4'd8
  } cmd_id_t;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {PS_KW, PS_NUM_X, PS_NUM_Y, PS_SKIP} parse_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} uart_state_t;

  // Longest table keyword is five letters, so only the last five characters matter.
  localparam int KW_TAIL_W = 40;

  function automatic cmd_id_t kw_lookup(input logic [KW_TAIL_W-1:0] tail, input int unsigned len);
    cmd_id_t id;
    id = CMD_NONE;
    case (len)
      2: if (tail[15:0] == "UP") id = CMD_UP;
      4: begin
        if (tail[31:0] == "DOWN")      id = CMD_DOWN;
        else if (tail[31:0] == "LEFT") id = CMD_LEFT;
      end
      5: begin
        if (tail == "RIGHT")      id = CMD_RIGHT;
        else if (tail == "PAINT") id = CMD_PAINT;
        else if (tail == "ERASE") id = CMD_ERASE;
        else if (tail == "CLEAR") id = CMD_CLEAR;
        else if (tail == "COLOR") id = CMD_COLOR;
      end
      default: id = CMD_NONE;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/teclado_rx_top_uart.sv
// 8N1 UART receiver with 2-flop synchronizer, mid-bit sampling and glitch rejection.
// byte_valid / frame_err pulse one cycle after the stop-bit sample.
module uart_rx_8n1 import teclado_pkg::*; #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int BIT_CLKS  = CLK_FREQ_HZ / BAUD;
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam int CW        = $clog2(BIT_CLKS);

  uart_state_t   state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic          rx_prev_q, rx_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RX_IDLE;
      sync_q       <= 2'b11;
      rx_prev_q    <= 1'b1;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      rx_prev_q    <= rx_prev_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sync_d       = {sync_q[0], rx};
    rx_prev_d    = rx_s;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d = RX_START;
          cnt_d   = CW'(HALF_CLKS - 1);
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          if (!rx_s) begin
            state_d = RX_DATA;
            cnt_d   = CW'(BIT_CLKS - 1);
            bit_d   = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = CW'(BIT_CLKS - 1);
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          state_d      = RX_IDLE;
          byte_valid_d = rx_s;
          frame_err_d  = !rx_s;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign data       = shift_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/teclado_rx_top.sv
// Line parser for "KEYWORD[,X[,Y]]<CR|LF>" commands received over the Bluetooth UART.
// Define TECLADO_CMD_ERR_EN to add the cmd_err pulse for rejected non-empty lines.
module teclado_rx_top import teclado_pkg::*; #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 9600,
  parameter int MAX_KW      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_bluetooth,
  output logic       cmd_valid,
  output logic [3:0] cmd_id,
  output logic [6:0] x,
  output logic [6:0] y
`ifdef TECLADO_CMD_ERR_EN
  ,
  output logic       cmd_err
`endif
);

  localparam int LW = $clog2(MAX_KW + 1);

  logic [7:0] rx_data;
  logic       rx_byte_valid;
  logic       rx_frame_err;

  uart_rx_8n1 #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD(BAUD)) u_uart (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx_bluetooth),
    .data       (rx_data),
    .byte_valid (rx_byte_valid),
    .frame_err  (rx_frame_err)
  );

  parse_state_t         state_q, state_d;
  logic [KW_TAIL_W-1:0] kw_q, kw_d;
  logic [LW-1:0]        kw_len_q, kw_len_d;
  logic [6:0]           x_acc_q, x_acc_d, y_acc_q, y_acc_d;
  logic [1:0]           x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic                 nonempty_q, nonempty_d;
  logic                 cmd_valid_q, cmd_valid_d;
  cmd_id_t              cmd_id_q, cmd_id_d;
  logic [6:0]           x_q, x_d, y_q, y_d;

  logic [7:0]  ch_upper;
  logic        is_term, is_space, is_comma, is_digit, is_alpha;
  logic [6:0]  cur_acc;
  logic [1:0]  cur_cnt;
  logic [10:0] num_sum;
  logic        num_ok;
  cmd_id_t     kw_id;

  always_comb begin
    ch_upper = rx_data;
    if (rx_data >= 8'h61 && rx_data <= 8'h7A) ch_upper = rx_data - 8'h20;
    is_term  = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
    is_space = (rx_data == ASCII_SPACE);
    is_comma = (rx_data == ASCII_COMMA);
    is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_alpha = (ch_upper >= 8'h41) && (ch_upper <= 8'h5A);
    cur_acc  = (state_q == PS_NUM_Y) ? y_acc_q : x_acc_q;
    cur_cnt  = (state_q == PS_NUM_Y) ? y_cnt_q : x_cnt_q;
    num_sum  = 11'(cur_acc) * 11'd10 + 11'(rx_data[3:0]);
    num_ok   = (cur_cnt != 2'd3) && (num_sum <= 11'd127);
    kw_id    = kw_lookup(kw_q, 32'(kw_len_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PS_KW;
      kw_q        <= '0;
      kw_len_q    <= '0;
      x_acc_q     <= '0;
      y_acc_q     <= '0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      nonempty_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_id_q    <= CMD_NONE;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      state_q     <= state_d;
      kw_q        <= kw_d;
      kw_len_q    <= kw_len_d;
      x_acc_q     <= x_acc_d;
      y_acc_q     <= y_acc_d;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      nonempty_q  <= nonempty_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_id_q    <= cmd_id_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    kw_d        = kw_q;
    kw_len_d    = kw_len_q;
    x_acc_d     = x_acc_q;
    y_acc_d     = y_acc_q;
    x_cnt_d     = x_cnt_q;
    y_cnt_d     = y_cnt_q;
    nonempty_d  = nonempty_q;
    cmd_valid_d = 1'b0;
    cmd_id_d    = cmd_id_q;
    x_d         = x_q;
    y_d         = y_q;
    if (rx_frame_err) begin
      state_d    = PS_SKIP;
      nonempty_d = 1'b1;
    end else if (rx_byte_valid) begin
      if (is_term) begin
        state_d    = PS_KW;
        kw_len_d   = '0;
        x_acc_d    = '0;
        y_acc_d    = '0;
        x_cnt_d    = '0;
        y_cnt_d    = '0;
        nonempty_d = 1'b0;
        if (state_q != PS_SKIP && nonempty_q && kw_id != CMD_NONE) begin
          cmd_valid_d = 1'b1;
          cmd_id_d    = kw_id;
          x_d         = x_acc_q;
          y_d         = y_acc_q;
        end
      end else if (!is_space) begin
        nonempty_d = 1'b1;
        case (state_q)
          PS_KW: begin
            if (is_alpha) begin
              if (kw_len_q == LW'(MAX_KW)) begin
                state_d = PS_SKIP;
              end else begin
                kw_d     = {kw_q[KW_TAIL_W-9:0], ch_upper};
                kw_len_d = kw_len_q + LW'(1);
              end
            end else if (is_comma) begin
              state_d = PS_NUM_X;
            end else begin
              state_d = PS_SKIP;
            end
          end
          PS_NUM_X: begin
            if (is_digit && num_ok) begin
              x_acc_d = num_sum[6:0];
              x_cnt_d = x_cnt_q + 2'd1;
            end else if (is_comma && x_cnt_q != 2'd0) begin
              state_d = PS_NUM_Y;
            end else begin
              state_d = PS_SKIP;
            end
          end
          PS_NUM_Y: begin
            // A comma here would be the third one on the line.
            if (is_digit && num_ok) begin
              y_acc_d = num_sum[6:0];
              y_cnt_d = y_cnt_q + 2'd1;
            end else begin
              state_d = PS_SKIP;
            end
          end
          default: state_d = PS_SKIP;
        endcase
      end
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_id    = cmd_id_q;
  assign x         = x_q;
  assign y         = y_q;

`ifdef TECLADO_CMD_ERR_EN
  logic cmd_err_q, cmd_err_d;

  assign cmd_err_d = rx_byte_valid && is_term &&
                     (state_q == PS_SKIP || (nonempty_q && kw_id == CMD_NONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmd_err_q <= 1'b0;
    else        cmd_err_q <= cmd_err_d;
  end

  assign cmd_err = cmd_err_q;
`endif

endmodule

// File: tb/tb_teclado_rx_top.sv
// Randomized line-level bench for teclado_rx_top against a string-based command model.
// UART runs at 8 clocks per bit to keep run time short.
module tb_teclado_rx_top;

  localparam int CLK_HZ  = 50_000_000;
  localparam int BAUD_TB = 6_250_000;
  localparam int BIT_NS  = 160;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_bluetooth = 1'b1;
  logic       cmd_valid;
  logic [3:0] cmd_id;
  logic [6:0] x, y;
`ifdef TECLADO_CMD_ERR_EN
  logic       cmd_err;
`endif

  always #10 clk = ~clk;

  teclado_rx_top #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_TB), .MAX_KW(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_bluetooth (rx_bluetooth),
    .cmd_valid    (cmd_valid),
    .cmd_id       (cmd_id),
    .x            (x),
    .y            (y)
`ifdef TECLADO_CMD_ERR_EN
    ,
    .cmd_err      (cmd_err)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_strobe = 0;
  int n_err    = 0;
  int exp_id = 0, exp_x = 0, exp_y = 0;

  string kw_pool[12] = '{"UP", "DOWN", "LEFT", "RIGHT", "PAINT", "ERASE", "CLEAR", "COLOR",
                         "JUMP", "UPP", "COLOURS", "LEFTRIGHT"};

  always @(negedge clk) begin
    if (cmd_valid) n_strobe++;
`ifdef TECLADO_CMD_ERR_EN
    if (cmd_err) n_err++;
`endif
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int kw_code(input string k);
    if (k == "UP")    return 1;
    if (k == "DOWN")  return 2;
    if (k == "LEFT")  return 3;
    if (k == "RIGHT") return 4;
    if (k == "PAINT") return 5;
    if (k == "ERASE") return 6;
    if (k == "CLEAR") return 7;
    if (k == "COLOR") return 8;
    return 0;
  endfunction

  // kind: 0 = empty line, 1 = valid command, 2 = rejected line
  function automatic void model_line(input string s, input bit framing_bad,
                                     output int kind, output int id, output int xv, output int yv);
    string t, f, k;
    string fields[$];
    int v, c, code, ax, ay;
    kind = 0; id = 0; xv = 0; yv = 0;
    t = "";
    for (int i = 0; i < s.len(); i++)
      if (s.getc(i) != 8'd32) t = {t, s.substr(i, i)};
    if (framing_bad) begin kind = 2; return; end
    if (t.len() == 0) return;
    kind = 2;
    f = "";
    for (int i = 0; i < t.len(); i++) begin
      if (t.getc(i) == 8'd44) begin fields.push_back(f); f = ""; end
      else f = {f, t.substr(i, i)};
    end
    fields.push_back(f);
    if (fields.size() > 3) return;
    k = fields[0];
    code = kw_code(k.toupper());
    if (code == 0) return;
    ax = 0; ay = 0;
    for (int n = 1; n < fields.size(); n++) begin
      f = fields[n];
      if (f.len() == 0 || f.len() > 3) return;
      v = 0;
      for (int i = 0; i < f.len(); i++) begin
        c = int'(f.getc(i));
        if (c < 48 || c > 57) return;
        v = v * 10 + (c - 48);
      end
      if (v > 127) return;
      if (n == 1) ax = v; else ay = v;
    end
    kind = 1; id = code; xv = ax; yv = ay;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx_bluetooth = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx_bluetooth = b[i];
      #(BIT_NS);
    end
    rx_bluetooth = ~bad_stop;
    #(BIT_NS);
    rx_bluetooth = 1'b1;
    if (bad_stop) #(BIT_NS);
    if ($urandom_range(0, 1) == 1) #(BIT_NS);
  endtask

  task automatic send_term(input int term);
    if (term == 1 || term == 2) send_byte(8'h0D, 1'b0);
    if (term == 0 || term == 2) send_byte(8'h0A, 1'b0);
  endtask

  // term: 0 = LF, 1 = CR, 2 = CR LF; bad_idx marks a character sent with a broken stop bit
  task automatic run_line(input string s, input int term, input int bad_idx, input string tag);
    int s0, e0, kind, id, xv, yv;
    s0 = n_strobe;
    e0 = n_err;
    model_line(s, bad_idx >= 0, kind, id, xv, yv);
    for (int i = 0; i < s.len(); i++) send_byte(s.getc(i), i == bad_idx);
    send_term(term);
    repeat (4) @(negedge clk);
    if (kind == 1) begin exp_id = id; exp_x = xv; exp_y = yv; end
    $display("line %s \"%s\" term %0d bad %0d: kind %0d -> id %0d x %0d y %0d (dut id %0d x %0d y %0d)",
             tag, s, term, bad_idx, kind, exp_id, exp_x, exp_y, cmd_id, x, y);
    check_eq({tag, ".strobes"}, n_strobe - s0, (kind == 1) ? 1 : 0);
    check_eq({tag, ".cmd_id"}, int'(cmd_id), exp_id);
    check_eq({tag, ".x"}, int'(x), exp_x);
    check_eq({tag, ".y"}, int'(y), exp_y);
`ifdef TECLADO_CMD_ERR_EN
    check_eq({tag, ".cmd_err"}, n_err - e0, (kind == 2) ? 1 : 0);
`endif
  endtask

  function automatic string gen_line();
    string s, k, c;
    int n, r;
    k = kw_pool[$urandom_range(0, 11)];
    s = ($urandom_range(0, 3) == 0) ? " " : "";
    for (int i = 0; i < k.len(); i++) begin
      c = k.substr(i, i);
      if ($urandom_range(0, 1) == 1) c = c.tolower();
      s = {s, c};
    end
    n = $urandom_range(0, 4);
    if (n == 4) n = 2;
    for (int a = 0; a < n; a++) begin
      s = {s, ","};
      if ($urandom_range(0, 4) == 0) s = {s, " "};
      r = $urandom_range(0, 11);
      if (r == 8 && a == n - 1) r = 0;
      case (r)
        6:       s = {s, $sformatf("%0d", $urandom_range(128, 999))};
        7:       s = {s, $sformatf("%04d", $urandom_range(0, 127))};
        8:       s = s;
        9:       s = {s, $sformatf("%0dq", $urandom_range(0, 99))};
        default: s = {s, $sformatf("%0d", $urandom_range(0, 127))};
      endcase
    end
    return s;
  endfunction

  initial begin
    int s0;
    logic [7:0] nb;
    repeat (3) @(negedge clk);
    check_eq("reset.cmd_valid", int'(cmd_valid), 0);
    check_eq("reset.cmd_id", int'(cmd_id), 0);
    check_eq("reset.x", int'(x), 0);
    check_eq("reset.y", int'(y), 0);
`ifdef TECLADO_CMD_ERR_EN
    check_eq("reset.cmd_err", int'(cmd_err), 0);
`endif
    rst_n = 1'b1;
    repeat (100) @(negedge clk);

    run_line("UP,12,4", 0, -1, "up");
    run_line("", 1, -1, "cr_only");
    run_line("", 0, -1, "lf_only");
    run_line("paint,127,0", 1, -1, "paint");
    run_line("CLEAR", 0, -1, "clear");
    run_line("UP,128,3", 0, -1, "big_num");
    run_line("JUMP", 0, -1, "unknown_kw");
    run_line("UP,1,2,3", 0, -1, "three_commas");
    run_line("LEFT,5,6", 0, 1, "frame_err");
    run_line("RIGHT,1,1", 0, -1, "right");
    run_line("COLOR,0012", 2, -1, "four_digits");
    run_line(" Erase , 7 ,99", 2, -1, "spaces");

    // Reset in the middle of the 'N' of "DOWN,3,3"
    s0 = n_strobe;
    send_byte("D", 1'b0);
    send_byte("O", 1'b0);
    send_byte("W", 1'b0);
    nb = 8'h4E;
    rx_bluetooth = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin rx_bluetooth = nb[i]; #(BIT_NS); end
    #3 rst_n = 1'b0;
    #2;
    check_eq("rst_mid.cmd_valid", int'(cmd_valid), 0);
    check_eq("rst_mid.cmd_id", int'(cmd_id), 0);
    check_eq("rst_mid.x", int'(x), 0);
    check_eq("rst_mid.y", int'(y), 0);
    exp_id = 0; exp_x = 0; exp_y = 0;
    #40 rst_n = 1'b1;
    #(BIT_NS - 45);
    for (int i = 4; i < 8; i++) begin rx_bluetooth = nb[i]; #(BIT_NS); end
    rx_bluetooth = 1'b1;
    #(BIT_NS);
    send_byte(",", 1'b0);
    send_byte("3", 1'b0);
    send_byte(",", 1'b0);
    send_byte("3", 1'b0);
    send_byte(8'h0A, 1'b0);
    #(20 * BIT_NS);
    send_byte(8'h0A, 1'b0);
    #(20 * BIT_NS);
    $display("line rst_mid: reset pulsed inside 'N', remainder sent, strobes seen %0d", n_strobe - s0);
    check_eq("rst_mid.strobes", n_strobe - s0, 0);
    check_eq("rst_mid.hold_id", int'(cmd_id), 0);
    run_line("DOWN,3,3", 0, -1, "rst_fresh");

    for (int i = 0; i < 16; i++)
      run_line(gen_line(), $urandom_range(0, 2), -1, $sformatf("rnd%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/teclado_rx_top.md
Name: teclado_rx_top

Overview:
- Receives ASCII text command lines over a UART link from the Bluetooth module.
- Parses each line of the form KEYWORD[,X[,Y]] and terminator.
- Emits one decoded command as a single-cycle strobe with command id and 7-bit coordinates.
- Sits between the Bluetooth RX pin and the retro_paint cursor/paint control logic.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency.
- BAUD, 9600, UART bit rate. Bit period is CLK_FREQ_HZ/BAUD clocks (5208 at defaults); the integer division truncates.
- MAX_KW, 8, maximum keyword length in characters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_bluetooth  in  1  UART RX line, idle high, 8N1, LSB first, asynchronous to clk.
- cmd_valid  out  1  one-cycle strobe when a complete valid command line has been parsed.
- cmd_id  out  4  command code; held until the next strobe.
- x  out  7  first numeric argument, 0..127; held.
- y  out  7  second numeric argument, 0..127; held.

Behaviour:
- Reset:
  - All outputs are 0.
  - UART idle; parser in the start-of-line state.
  - Reset asserted mid-frame or mid-line abandons it completely.
- UART RX:
  - rx_bluetooth goes through a 2-flop synchronizer.
  - A falling edge in IDLE starts a half-bit wait. If the line is still 0 at mid start bit, go to DATA; otherwise return to IDLE (glitch rejected).
  - Eight data bits are sampled at mid-bit, LSB first. Then the stop bit is sampled.
  - Stop bit = 1: byte_valid pulses for 1 cycle, in the cycle after the stop sample.
  - Stop bit = 0: framing error; byte discarded; the current line is marked bad.
- Parser states: KW, NUM_X, NUM_Y, SKIP.
- KW state:
  - Letters A-Z are accumulated; lowercase is folded to upper.
  - ',' moves to NUM_X.
  - Terminator is CR (0x0D) or LF (0x0A).
- NUM_X / NUM_Y states:
  - Decimal digits accumulate as val*10+digit, at most 3 digits.
  - ',' moves NUM_X to NUM_Y.
- Space (0x20) is ignored in all states.
- Keyword table:
  - UP=1, DOWN=2, LEFT=3, RIGHT=4, PAINT=5, ERASE=6, CLEAR=7, COLOR=8.
  - Matching is exact and full-length.
- Line-level errors (enter SKIP; nothing emitted until the next terminator, then return to KW):
  - unknown keyword
  - keyword longer than MAX_KW
  - any other character
  - fourth digit in a number, or value > 127
  - third comma
  - comma with no preceding digits
  - framing error
- On terminator with a valid line:
  - cmd_valid=1 for exactly 1 cycle, the cycle after byte_valid.
  - cmd_id, x and y update in the same cycle.
  - Missing arguments read as 0.
- Empty line (terminator with no non-space chars): ignored, no strobe. "CR LF" and "LF CR LF" therefore yield one command only.
- Terminator while in SKIP: no strobe; return to KW.
- cmd_id, x and y never change except on a strobe.

Optional Feature:
- Macro TECLADO_CMD_ERR_EN.
- Defined:
  - Extra output port cmd_err (1 bit, reset 0).
  - cmd_err pulses 1 cycle on the terminator of any non-empty line rejected as an error.
  - Same timing as cmd_valid; the two are mutually exclusive.
- Undefined: port absent; errors are silently dropped.

Decomposition:
- Package teclado_pkg:
  - cmd_id_t (4-bit) with enumerated codes NONE=0 .. COLOR=8.
  - ASCII constants CR, LF, COMMA, SPACE.
  - Parser state typedef.
- One sub-module uart_rx_8n1: parameters CLK_FREQ_HZ and BAUD; outputs data[7:0], byte_valid, frame_err.
- The parser lives in teclado_rx_top.

Test Plan:
- Send "UP,12,4" LF, then CR, then LF at 9600 baud (104167 ns/bit) after 1 ms idle:
  - exactly one cmd_valid, with cmd_id=1, x=12, y=4;
  - the following CR and LF produce no strobe;
  - outputs hold afterwards.
- Send "paint,127,0" CR -> one strobe, cmd_id=5, x=127, y=0.
- Send "CLEAR" LF -> cmd_id=7, x=0, y=0.
- Send "UP,128,3" LF, then "JUMP" LF, then "UP,1,2,3" LF:
  - no strobe for any of them; prior outputs unchanged;
  - with TECLADO_CMD_ERR_EN, three cmd_err pulses.
- Send "LEFT,5,6" with a corrupt stop bit on 'E', then LF:
  - line dropped;
  - next "RIGHT,1,1" LF gives cmd_id=4, x=1, y=1.
- Pulse rst_n low mid-byte during "DOWN,3,3":
  - outputs go to 0 immediately;
  - the remainder is parsed as a bad or empty line;
  - a fresh "DOWN,3,3" LF gives cmd_id=2, x=3, y=3.
